// File: rtl/approx_mul8_sequencer.sv
// 8x8 unsigned multiply sequenced over one external 4x4 core, four nibble steps.
// Optional APPROX_SKIP_LL_EN drops the AL*BL step (low nibble of result forced 0).
module approx_mul8_sequencer #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_sat,
  output logic        busy,
  output logic        mul_en,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [2:0] LAT = 3'(MUL_LAT);

`ifdef APPROX_SKIP_LL_EN
  localparam logic [1:0] FIRST_STEP = 2'd1;
`else
  localparam logic [1:0] FIRST_STEP = 2'd0;
`endif

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [16:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [2:0]  wait_q, wait_d;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [16:0] addend;
  logic        run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
    end
  end

  // step[1] picks the A nibble, step[0] the B nibble
  always_comb begin
    nib_a = step_q[1] ? a_q[7:4] : a_q[3:0];
    nib_b = step_q[0] ? b_q[7:4] : b_q[3:0];
    addend = {9'd0, mul_p};
    unique case (step_q)
      2'd0:    addend = {9'd0, mul_p};
      2'd3:    addend = {1'b0, mul_p, 8'd0};
      default: addend = {5'd0, mul_p, 4'd0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          step_d  = FIRST_STEP;
          wait_d  = '0;
          state_d = (in_a == 8'd0 || in_b == 8'd0) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (wait_q == LAT) begin
          acc_d  = acc_q + addend;
          wait_d = '0;
          if (step_q == 2'd3) begin
            state_d = HOLD;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run       = (state_q == RUN);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);
  assign mul_en    = run;
  assign mul_a     = run ? nib_a : 4'd0;
  assign mul_b     = run ? nib_b : 4'd0;
  assign out_sat   = acc_q[16];
  assign out_p     = acc_q[16] ? 16'hFFFF : acc_q[15:0];

endmodule

// File: doc/approx_mul8_sequencer.md
Name: approx_mul8_sequencer

Overview:
- Sequencer that computes one 8x8 unsigned product by time-multiplexing a single external 4x4 multiplier core over four nibble partial products, accumulating with shifts.
- The core is normally the team's approximate 4x4 multiplier; the block is core-agnostic.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Allows one small core to serve 8-bit datapaths at reduced throughput.

Parameters:
- MUL_LAT, 0: cycles between operands presented on mul_a/mul_b and a valid mul_p. 0 = combinational core. Legal range 0..7.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  8  multiplicand
- in_b  in  8  multiplier
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_p  out  16  product, saturated
- out_sat  out  1  accumulation exceeded 16 bits; out_p forced to 0xFFFF
- busy  out  1  high in RUN or HOLD
- mul_en  out  1  core enable, high only in RUN
- mul_a  out  4  core operand A
- mul_b  out  4  core operand B
- mul_p  in  8  core product

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; operand, accumulator and step registers cleared.
  - in_ready=1; out_valid=0; out_p=0; out_sat=0; busy=0; mul_en=0; mul_a=0; mul_b=0.
- State machine, states IDLE, RUN, HOLD:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, latch in_a/in_b, clear the 17-bit accumulator, set step=0, wait=0.
    - If in_a==0 or in_b==0: go to HOLD with out_p=0 and out_sat=0; out_valid=1 in cycle T+1; core never enabled.
    - Otherwise go to RUN.
  - RUN: mul_en=1. mul_a/mul_b are driven from registers and held stable for the whole step. Step order, with nibbles L=[3:0] and H=[7:4]:
    - step0: AL*BL, shift 0
    - step1: AL*BH, shift 4
    - step2: AH*BL, shift 4
    - step3: AH*BH, shift 8
  - Each step lasts MUL_LAT+1 cycles. On the last cycle of the step, at the edge, the accumulator adds the shifted mul_p.
  - After step3 accumulates, go to HOLD.
  - HOLD: out_valid=1. out_p and out_sat stay stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: for a nonzero accept at edge T, out_valid asserts in cycle T+1+4*(MUL_LAT+1). With MUL_LAT=0 that is T+5.
- No overlap. in_ready=0 in RUN and HOLD. The next accept is possible in the cycle after the out handshake, so throughput is 1 product per 4*(MUL_LAT+1)+2 cycles minimum.
- Arithmetic:
  - The 17-bit accumulator holds the exact sum of the shifted core outputs.
  - An approximate core can yield a sum above 0xFFFF (max 73695). If accumulator[16]=1 at HOLD entry: out_p=0xFFFF, out_sat=1. Otherwise out_p=accumulator[15:0], out_sat=0.
- Operands are not sampled outside IDLE; in_a/in_b changes during RUN are ignored.
- out_ready held high while out_valid=0 has no effect.
- mul_p is ignored when mul_en=0 and on non-final cycles of a step.
- Reset asserted mid-RUN or mid-HOLD aborts immediately. The result is discarded and no out_valid is produced.

Optional Feature:
- APPROX_SKIP_LL_EN.
- Defined: step0 (AL*BL) is omitted; RUN performs steps 1..3 only. out_p[3:0] is always 0, with further truncation error. Latency is T+1+3*(MUL_LAT+1).
- Undefined: all four steps run as above.

Test Plan:
1. MUL_LAT=0, exact 4x4 core model, in_a=0xFF, in_b=0xFF accepted at T -> mul_a/mul_b sequence F/F each cycle T+1..T+4. out_valid at T+5 with out_p=0xFE01, out_sat=0.
2. MUL_LAT=2, exact core, in_a=0x3C, in_b=0xA5 -> each operand pair held 3 cycles. out_valid at T+13 with out_p=0x26AC.
3. in_a=0x00, in_b=0x7E -> mul_en stays 0. out_valid at T+1 with out_p=0x0000.
4. Core stub returning mul_p=0xFF always, in_a=0x11, in_b=0x11 -> out_p=0xFFFF, out_sat=1.
5. out_ready held low 10 cycles in HOLD, in_valid held high with new operands -> out_p stable, in_ready=0 throughout. After the handshake, in_ready=1 the next cycle and the second product is correct.
6. rst_n pulsed low during RUN step2 -> all outputs return to reset values asynchronously. The next transaction 0x02*0x03 gives out_p=0x0006.
